// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared 640x480@60 timing defaults and coordinate type
// Revision: 1.0
// ============================================================================
package vga_timing_pkg;

   localparam int COORD_W       = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   typedef logic [COORD_W-1:0] coord_t;

   // Period of one axis: visible + front porch + sync + back porch.
   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_axis_counter : modulo pixel/line counter with registered sync/visible
// Revision: 1.0
// ============================================================================
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_en,
   output coord_t o_count,
   output logic   o_wrap,
   output logic   o_sync_n,
   output logic   o_visible
);

   localparam int     c_total      = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam coord_t c_last       = coord_t'(c_total - 1);
   localparam coord_t c_vis_end    = coord_t'(VISIBLE);
   localparam coord_t c_sync_start = coord_t'(VISIBLE + FRONT);
   localparam coord_t c_sync_end   = coord_t'(VISIBLE + FRONT + SYNC);

   coord_t r_count;
   logic   r_sync_n;
   logic   r_visible;
   logic   w_at_last;
   coord_t w_next;

   assign w_at_last = (r_count == c_last);
   assign w_next    = w_at_last ? '0 : r_count + coord_t'(1);
   // Combinational so the next axis can advance on the very same edge.
   assign o_wrap    = i_en & w_at_last;

   // Decode is taken from the next count so flags stay aligned with o_count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= c_last;
         r_sync_n  <= 1'b1;
         r_visible <= 1'b0;
      end else if (i_en) begin
         r_count   <= w_next;
         r_sync_n  <= !((w_next >= c_sync_start) && (w_next < c_sync_end));
         r_visible <= (w_next < c_vis_end);
      end
   end

   assign o_count   = r_count;
   assign o_sync_n  = r_sync_n;
   assign o_visible = r_visible;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA raster timing (sync, blank, coordinates, frame pulses)
// Revision: 1.0
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic               enable,
   output logic               hs,
   output logic               vs,
   output logic               blank,
   output logic [COORD_W-1:0] DrawX,
   output logic [COORD_W-1:0] DrawY,
   output logic               line_start,
   output logic               frame_start,
   output logic [7:0]         frame_count
);

   logic w_h_wrap;
   logic w_v_wrap;
   logic w_h_vis;
   logic w_v_vis;
   logic r_line_start;
   logic r_frame_start;
   logic [7:0] r_frame_count;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk       (vga_clk),
      .rst_n     (reset_n),
      .i_en      (enable),
      .o_count   (DrawX),
      .o_wrap    (w_h_wrap),
      .o_sync_n  (hs),
      .o_visible (w_h_vis)
   );

   // Vertical axis steps only when the line wraps, so vs changes on whole lines.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk       (vga_clk),
      .rst_n     (reset_n),
      .i_en      (w_h_wrap),
      .o_count   (DrawY),
      .o_wrap    (w_v_wrap),
      .o_sync_n  (vs),
      .o_visible (w_v_vis)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
         if (w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   // Both visibility flags are flops updated on the same edge as the counters.
   assign blank       = w_h_vis & w_v_vis;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_VISIBLE, V_FRONT, V_SYNC and V_BACK, defaults 480, 10, 2 and 33, vertical equivalents of REQ-001 to REQ-004 in lines.
REQ-006 SHALL have port vga_clk, input, 1 bit, pixel clock; the only clock.
REQ-007 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1 bit, advance one pixel per vga_clk edge when high.
REQ-009 SHALL have port hs, output, 1 bit, horizontal sync, active low.
REQ-010 SHALL have port vs, output, 1 bit, vertical sync, active low.
REQ-011 SHALL have port blank, output, 1 bit, high = active video (pixel data valid), low = blanking.
REQ-012 SHALL have ports DrawX and DrawY, output, 10 bits each, current pixel column and row.
REQ-013 SHALL have ports line_start and frame_start, output, 1 bit each, one-cycle pulses.
REQ-014 SHALL have port frame_count, output, 8 bits, count of completed frame starts.

Function
REQ-015 SHALL define H_TOTAL as the sum of the four horizontal parameters (800 by default) and V_TOTAL likewise (525 by default).
REQ-016 SHALL, on each vga_clk rising edge with enable=1, increment DrawX; from H_TOTAL-1 it wraps to 0 and DrawY increments.
REQ-017 SHALL wrap DrawY from V_TOTAL-1 to 0 when DrawX wraps.
REQ-018 SHALL hold every output unchanged on an edge with enable=0, except that line_start and frame_start go to 0.
REQ-019 SHALL register all outputs and keep them cycle-aligned with DrawX/DrawY, with no combinational path from inputs to outputs.
REQ-020 SHALL drive blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE.
REQ-021 SHALL drive hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-022 SHALL drive vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), for whole lines.
REQ-023 SHALL assert line_start for exactly one cycle after an enabled edge that produces DrawX=0.
REQ-024 SHALL assert frame_start for exactly one cycle after an enabled edge that produces DrawX=0 and DrawY=0.
REQ-025 SHALL increment frame_count on the same edge that asserts frame_start, wrapping from 255 to 0.
REQ-026 SHALL have a first enabled edge after reset release that produces DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1 and frame_count=1.

Reset
REQ-027 SHALL, while reset_n=0 (asynchronously), force DrawX=H_TOTAL-1, DrawY=V_TOTAL-1, hs=1, vs=1, blank=0, line_start=0, frame_start=0 and frame_count=0.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame immediately; after release, output restarts per REQ-026.

Structure
REQ-029 SHALL take the default timing constants, the derived H_TOTAL/V_TOTAL and the 10-bit coordinate width from a shared package vga_timing_pkg.
REQ-030 SHALL implement each axis with one sub-module, vga_axis_counter (modulo counter with enable, wrap-pulse output and registered sync/visible decode), instantiated twice.

Verification
REQ-031 SHALL cover reset: hold reset_n=0 -> DrawX=799, DrawY=524, hs=1, vs=1, blank=0, frame_count=0.
REQ-032 SHALL cover first pixel: release reset with enable=1, one edge -> DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1, line_start=1.
REQ-033 SHALL cover horizontal sync: hs=0 for exactly 96 consecutive cycles, DrawX 656..751; blank=0 from DrawX 640; line wraps 799->0 with DrawY+1.
REQ-034 SHALL cover vertical sync and frame wrap: vs=0 for DrawY 490..491 (1600 cycles); (799,524)->(0,0) with frame_start=1; full frame = 420000 enabled cycles.
REQ-035 SHALL cover stall: enable=0 for 10 cycles at DrawX=100 -> all coordinates held; line_start/frame_start=0; resume continues from DrawX=101.
REQ-036 SHALL cover wrap and mid-frame reset: after 256 frames frame_count=0; reset_n pulsed low at (300,200) -> REQ-027 values immediately, then REQ-032 sequence.
